// File: rtl/sequence_player.sv
// Playback engine for the sequence game: walks a synchronous ROM from address 0
// to a latched limit, lighting each note for ON_CYCLES with OFF_CYCLES blank gaps.
module sequence_player #(
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250,
  parameter int CNT_W      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] limit,
  input  logic [6:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [6:0] leds,
  output logic       busy,
  output logic       done,
  output logic [2:0] db_state
);

  // Control unit handshake: start is a level sampled only in IDLE (no edge
  // detection), stop aborts from any state, done pulses once per completed run.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHOW  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [3:0]       limit_reg;
  logic [6:0]       note_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      limit_reg <= '0;
      note_reg  <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (stop) begin
      state    <= S_IDLE;
      timer    <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          timer    <= '0;
          rom_addr <= '0;
          done     <= 1'b0;
          if (start) begin
            limit_reg <= limit;
            state     <= S_FETCH;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        // Two cycles: one for the address to reach the ROM, one for its output register.
        S_FETCH: begin
          if (timer == FETCH_LAST) begin
            note_reg <= rom_data;
            timer    <= '0;
            state    <= S_SHOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_SHOW: begin
          if (timer == ON_LAST) begin
            timer <= '0;
            if (rom_addr == limit_reg) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_GAP: begin
          if (timer == OFF_LAST) begin
            timer    <= '0;
            rom_addr <= rom_addr + 4'd1;
            state    <= S_FETCH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DONE: begin
          timer    <= '0;
          done     <= 1'b0;
          busy     <= 1'b0;
          rom_addr <= '0;
          state    <= S_IDLE;
        end

        default: begin
          timer    <= '0;
          done     <= 1'b0;
          busy     <= 1'b0;
          rom_addr <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // The note register is only visible on the LEDs while in SHOW.
  assign leds     = (state == S_SHOW) ? note_reg : 7'd0;
  assign db_state = state;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with short timings (ON=4, OFF=2) and a
// behavioural one-cycle-latency ROM.
module tb_sequence_player;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int PER = 2 + ON + OFF;

  logic       clock = 1'b0;
  logic       reset, start, stop;
  logic [3:0] limit;
  logic [6:0] rom_data;
  logic [3:0] rom_addr;
  logic [6:0] leds;
  logic       busy, done;
  logic [2:0] db_state;

  logic [6:0] rom_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(13)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .limit(limit),
    .rom_data(rom_data), .rom_addr(rom_addr), .leds(leds), .busy(busy),
    .done(done), .db_state(db_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom_mem[rom_addr];

  typedef struct {
    int lim;
    int pulse_k;    // cycle in which start=1 with limit=5 is injected (0 = none)
    int stop_k;     // cycle in which stop is asserted (0 = none)
    int exp_busy;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent timeline: cycle k (1-based after start sampled) of a run with given limit.
  task automatic expect_at(input int lim, input int k, input int stop_k,
                           output logic [6:0] e_leds, output logic [2:0] e_st,
                           output logic [3:0] e_addr, output logic e_busy,
                           output logic e_done, output logic addr_valid);
    int final_k, n, off;
    final_k = lim * PER + 2 + ON + 1;
    e_leds = '0; e_st = 3'd0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0; addr_valid = 1'b1;
    if (stop_k != 0 && k > stop_k) return;
    if (k < final_k) begin
      n   = (k - 1) / PER;
      off = (k - 1) % PER;
      e_busy = 1'b1;
      e_addr = 4'(n);
      if (off < 2) e_st = 3'd1;
      else if (off < 2 + ON) begin
        e_st   = 3'd2;
        e_leds = rom_mem[n];
      end else e_st = 3'd3;
    end else if (k == final_k) begin
      e_st = 3'd4; e_busy = 1'b1; e_done = 1'b1; addr_valid = 1'b0;
    end
  endtask

  // driver: run one table row and compare every cycle against the timeline
  task automatic run_vec(input int idx);
    vec_t v;
    int span, busy_cnt, done_cnt;
    logic [6:0] e_leds; logic [2:0] e_st; logic [3:0] e_addr;
    logic e_busy, e_done, av;
    logic [31:0] act, exp;
    v = vecs[idx];
    span = (v.stop_k != 0) ? v.stop_k + 3 : v.lim * PER + 2 + ON + 4;
    busy_cnt = 0; done_cnt = 0;
    @(negedge clock);
    start = 1'b1; limit = 4'(v.lim);
    for (int k = 1; k <= span; k++) begin
      @(negedge clock);
      if (k == 1 || k == v.pulse_k + 1) start = 1'b0;
      if (k == v.stop_k + 1) stop = 1'b0;
      expect_at(v.lim, k, v.stop_k, e_leds, e_st, e_addr, e_busy, e_done, av);
      act = {12'd0, leds, db_state, (av ? rom_addr : 4'd0), busy, done};
      exp = {12'd0, e_leds, e_st, e_addr, e_busy, e_done};
      if (act !== exp) $display("  row %0d cycle %0d", idx, k);
      check($sformatf("trace_row%0d_k%0d", idx, k), act, exp);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (k == v.pulse_k) begin start = 1'b1; limit = 4'd5; end
      if (k == v.stop_k) stop = 1'b1;
    end
    check($sformatf("busy_cycles_row%0d", idx), 32'(busy_cnt), 32'(v.exp_busy));
    check($sformatf("done_pulses_row%0d", idx), 32'(done_cnt), 32'(v.exp_done));
  endtask

  initial begin
    // ROM: one-hot rotating patterns; last entry all-zero to cover a blank note.
    for (int i = 0; i < 15; i++) rom_mem[i] = 7'(1 << (i % 7));
    rom_mem[15] = 7'd0;

    vecs[0] = '{lim: 0,  pulse_k: 0, stop_k: 0,  exp_busy: 7,   exp_done: 1};
    vecs[1] = '{lim: 2,  pulse_k: 0, stop_k: 0,  exp_busy: 23,  exp_done: 1};
    vecs[2] = '{lim: 3,  pulse_k: 0, stop_k: 12, exp_busy: 12,  exp_done: 0};
    vecs[3] = '{lim: 1,  pulse_k: 0, stop_k: 0,  exp_busy: 15,  exp_done: 1};
    vecs[4] = '{lim: 2,  pulse_k: 4, stop_k: 0,  exp_busy: 23,  exp_done: 1};
    vecs[5] = '{lim: 15, pulse_k: 0, stop_k: 0,  exp_busy: 127, exp_done: 1};
    vecs[6] = '{lim: 7,  pulse_k: 0, stop_k: 0,  exp_busy: 63,  exp_done: 1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; limit = 4'd0;
    repeat (2) @(negedge clock);
    check("reset_outputs", {17'd0, leds, rom_addr, busy, done, db_state},
          {17'd0, 7'd0, 4'd0, 1'b0, 1'b0, 3'd0});
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {29'd0, db_state}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i);

    // start held high: restart on the first IDLE cycle after DONE
    @(negedge clock);
    start = 1'b1; limit = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 7) check("hold_done", {31'd0, done}, 32'd1);
      if (k == 8) check("hold_idle", {28'd0, busy, db_state}, 32'd0);
      if (k == 9) check("hold_restart", {29'd0, db_state}, 32'd1);
    end
    // stop and start together: stop wins, even in IDLE
    stop = 1'b1;
    @(negedge clock);
    check("stop_from_fetch", {28'd0, busy, db_state}, 32'd0);
    @(negedge clock);
    check("stop_beats_start_idle", {28'd0, busy, db_state}, 32'd0);
    stop = 1'b0; start = 1'b0;
    repeat (2) @(negedge clock);

    // reset with stop and start high during GAP
    start = 1'b1; limit = 4'd2;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
    end
    check("in_gap", {29'd0, db_state}, 32'd3);
    reset = 1'b1; stop = 1'b1; start = 1'b1; limit = 4'd9;
    @(negedge clock);
    check("reset_mid_outputs", {17'd0, leds, rom_addr, busy, done, db_state},
          {17'd0, 7'd0, 4'd0, 1'b0, 1'b0, 3'd0});
    check("reset_mid_limit_reg", {28'd0, dut.limit_reg}, 32'd0);
    reset = 1'b0; stop = 1'b0; start = 1'b0;
    @(negedge clock);
    check("idle_after_mid_reset", {28'd0, busy, db_state}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
Name: sequence_player

Overview:
Playback side of the sequence game. On `start`, the block reads the expected sequence from a synchronous 7-bit ROM (addresses 0..limit). It drives each entry onto the LEDs for a fixed on-time, with a blank gap between entries. When the last entry has been shown it pulses `done`. The block sits between the control unit and the ROM/LED mux, feeding the same one-hot patterns the player must later reproduce on the buttons.

Parameters:
- ON_CYCLES, 500, clock cycles each note is lit (>=1)
- OFF_CYCLES, 250, clock cycles of blank gap between notes (>=1)
- CNT_W, 13, timer width; must satisfy 2^CNT_W > max(ON_CYCLES, OFF_CYCLES)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- start  in  1  begin playback; sampled only in IDLE
- stop  in  1  abort playback; synchronous, any state
- limit  in  4  index of last note to play (inclusive); latched on accepted start
- rom_data  in  7  data_out of the external sync ROM (1-cycle read latency)
- rom_addr  out  4  address to the external ROM
- leds  out  7  one-hot note pattern while showing, 0 otherwise
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when playback completes normally
- db_state  out  3  state code: IDLE=0, FETCH=1, SHOW=2, GAP=3, DONE=4

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Reset: state=IDLE, rom_addr=0, limit_reg=0, note register=0, timer=0, leds=0, busy=0, done=0, db_state=0.
- Priority: reset > stop > normal transitions.
- IDLE: leds=0, rom_addr=0. `start`=1 latches `limit` into limit_reg, sets rom_addr=0 and moves to FETCH. `start` in any other state is ignored and `limit` changes are ignored.
- FETCH: lasts exactly 2 cycles, which covers the ROM register stage. At the end of the 2nd cycle, `rom_data` is latched into the note register and the state moves to SHOW. leds=0 during FETCH. rom_addr is held stable for the whole of FETCH.
- SHOW: lasts exactly ON_CYCLES cycles with leds=note register. At the end of the last cycle:
  - if rom_addr==limit_reg, go to DONE;
  - else go to GAP.
- GAP: lasts exactly OFF_CYCLES cycles with leds=0. At the end, rom_addr increments by 1 and the state returns to FETCH.
- DONE: exactly 1 cycle with done=1, busy=1, leds=0. Then IDLE with rom_addr=0.
- Timing, with `start` sampled at the end of cycle 0:
  - FETCH occupies cycles 1-2; the first note is lit in cycles 3..ON_CYCLES+2.
  - Each non-final note costs 2+ON_CYCLES+OFF_CYCLES cycles. The final note costs 2+ON_CYCLES cycles, followed by 1 DONE cycle.
  - Total busy time is (limit+1)*(2+ON_CYCLES) + limit*OFF_CYCLES + 1 cycles.
- The timer resets to 0 on every state entry. It counts up and the exit condition is timer==PARAM-1. There is no overflow given the CNT_W constraint.
- rom_addr never exceeds limit_reg. limit=15 plays all 16 entries with no wrap. limit=0 plays exactly one note and there is no GAP.
- An all-zero ROM entry is played normally (leds stays 0 for the on-time).
- `stop`: on the next edge the state goes to IDLE, leds=0, rom_addr=0, busy=0, and no done pulse. If `stop` and `start` are both high in IDLE, stop wins and nothing starts.
- Reset mid-playback behaves the same as stop, and also clears limit_reg.
- `start` held high continuously: after DONE→IDLE, playback restarts on the first IDLE cycle. There is no edge detection; the control unit is responsible for pulsing `start`.

Test Plan:
All scenarios use ON_CYCLES=4, OFF_CYCLES=2 and a behavioural sync ROM with contents 0000001, 0000010, 0000100, 0001000, …

1. reset held 2 cycles → leds=0, rom_addr=0, busy=0, done=0, db_state=0. Then start with limit=0 → leds=0000001 in cycles 3-6, done=1 in cycle 7 only, busy high cycles 1-7.
2. limit=2 → leds sequence 0000001 ×4, 0 ×4 (2 GAP + 2 FETCH), 0000010 ×4, 0 ×4, 0000100 ×4, then done. Total busy = 3*6 + 2*2 + 1 = 23 cycles. rom_addr steps 0→1→2 only at GAP exit.
3. stop asserted in 2nd SHOW cycle of note 1 (limit=3) → next cycle IDLE, leds=0, busy=0, done never pulses. A subsequent start replays from address 0.
4. start pulsed during SHOW with limit input changed to 5 → ignored: playback ends after the originally latched limit, with exactly one done pulse.
5. limit=15 → 16 notes played, rom_addr reaches 15 and never 0 again before DONE. Busy = 16*6 + 15*2 + 1 = 127 cycles.
6. reset asserted during GAP with stop and start also high → IDLE next cycle, all outputs at reset values, limit_reg=0.
